// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared constants, FSM state encoding and cell access helpers for the 4x4
// tile board. A board is 16 cells of 4 bits, packed so that cell 0 sits in
// bits [63:60] and cell 15 in bits [3:0]. A cell holds log2 of the tile value
// (0 = empty, 1 = 2, 2 = 4, ... 4'hB = 2048).
//
// Optional feature macro: TILE_FOUR_EN (lets pick_tile return a 4-tile).
// -----------------------------------------------------------------------------
package board_pkg;

    localparam int          CELL_W     = 4;
    localparam int          N_CELLS    = 16;
    localparam logic [3:0]  TILE_EMPTY = 4'h0;
    localparam logic [3:0]  TILE_2     = 4'h1;
    localparam logic [3:0]  TILE_4     = 4'h2;
    localparam logic [3:0]  TILE_WIN   = 4'hB;
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        PLACE = 2'd2
    } state_t;

    // Read cell idx out of a packed board (cell 0 is the most significant).
    function automatic logic [3:0] get_cell(input logic [63:0] board,
                                            input logic [3:0]  idx);
        return board[(N_CELLS - 1 - int'(idx)) * CELL_W +: CELL_W];
    endfunction

    // Return a copy of the board with cell idx replaced by val.
    function automatic logic [63:0] put_cell(input logic [63:0] board,
                                             input logic [3:0]  idx,
                                             input logic [3:0]  val);
        logic [63:0] b;
        b = board;
        b[(N_CELLS - 1 - int'(idx)) * CELL_W +: CELL_W] = val;
        return b;
    endfunction

    // Tile value for a new placement, chosen from the current LFSR state.
    // The 4-tile comes up with probability 1/16 when enabled.
    function automatic logic [3:0] pick_tile(input logic [15:0] lfsr);
`ifdef TILE_FOUR_EN
        return (lfsr[7:4] == 4'h0) ? TILE_4 : TILE_2;
`else
        return (lfsr == 16'h0) ? TILE_2 : TILE_2;
`endif
    endfunction

endpackage

// File: rtl/tile_lfsr.sv
// -----------------------------------------------------------------------------
// tile_lfsr
// Free-running 16-bit Fibonacci LFSR, taps 16, 14, 13, 11, advancing on every
// rising clock edge. Reset loads LFSR_SEED, which is non-zero, so the register
// never locks up in the all-zero state.
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous active-low reset
//   lfsr     out  current LFSR state [15:0]
// -----------------------------------------------------------------------------
module tile_lfsr
    import board_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    output logic [15:0] lfsr
);

    logic feedback;

    // Tap numbers are 1-based positions, hence bits 15, 13, 12, 10.
    assign feedback = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], feedback};
        end
    end

endmodule

// File: rtl/tile_board.sv
// -----------------------------------------------------------------------------
// tile_board
// Registered 4x4 game board. The board can be overwritten in one cycle with
// `update`, and `spawn` starts a search for an empty cell from a random start
// index; the search probes one cell per cycle, wrapping mod 16, and either
// places a new tile (pulse `spawned`) or gives up after 16 occupied probes
// (pulse `nofree`).
//
// Handshake: `spawn` is a request sampled only while `busy`=0; requests seen
// while `busy`=1 are dropped, not queued. `update` is always accepted and
// takes priority over an in-flight search, which it cancels silently (the
// search restarts on the new board if `spawn` is also high).
//
// Optional feature macro: TILE_FOUR_EN (occasionally place a 4-tile).
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   update     in   load newvalues into the board this cycle
//   newvalues  in   [63:0] board to load, cell 0 in [63:60]
//   spawn      in   request one new tile in a random empty cell
//   oldvalues  out  [63:0] registered board contents
//   busy       out  high while a search/placement is in progress
//   spawned    out  one-cycle pulse when a tile is written
//   nofree     out  one-cycle pulse when the search found no empty cell
// -----------------------------------------------------------------------------
module tile_board
    import board_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        update,
    input  logic [63:0] newvalues,
    input  logic        spawn,
    output logic [63:0] oldvalues,
    output logic        busy,
    output logic        spawned,
    output logic        nofree
);

    state_t      state, state_next;
    logic [3:0]  idx, idx_next;
    logic [4:0]  cnt, cnt_next;     // occupied probes so far, 0..16
    logic [63:0] board, board_next;
    logic        spawned_next, nofree_next;
    logic [15:0] lfsr;

    tile_lfsr u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .lfsr    (lfsr)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx     <= 4'h0;
            cnt     <= 5'd0;
            board   <= 64'h0;
            spawned <= 1'b0;
            nofree  <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            cnt     <= cnt_next;
            board   <= board_next;
            spawned <= spawned_next;
            nofree  <= nofree_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        cnt_next     = cnt;
        board_next   = board;
        spawned_next = 1'b0;
        nofree_next  = 1'b0;

        if (update) begin
            // A load always wins; a search in flight is dropped without a
            // pulse, and restarts on the new board if spawn is also high.
            board_next = newvalues;
            if (spawn) begin
                state_next = SCAN;
                idx_next   = lfsr[3:0];
                cnt_next   = 5'd0;
            end else if (state != IDLE) begin
                state_next = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (spawn) begin
                        state_next = SCAN;
                        idx_next   = lfsr[3:0];
                        cnt_next   = 5'd0;
                    end
                end
                SCAN: begin
                    // The give-up check comes one cycle after the 16th
                    // occupied probe, so that a full board and a hole found
                    // on the last probe both finish 17 cycles after entry.
                    if (cnt == 5'(N_CELLS)) begin
                        nofree_next = 1'b1;
                        state_next  = IDLE;
                    end else if (get_cell(board, idx) == TILE_EMPTY) begin
                        state_next = PLACE;
                    end else begin
                        idx_next = idx + 4'h1;
                        cnt_next = cnt + 5'd1;
                    end
                end
                PLACE: begin
                    board_next   = put_cell(board, idx, pick_tile(lfsr));
                    spawned_next = 1'b1;
                    state_next   = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign oldvalues = board;
    assign busy      = (state != IDLE);

endmodule
